// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sub16.sv
// rtl/sub16.sv - combinational ripple subtractor built from full-subtractor cells
module sub16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH:0] w_bchain;

    assign w_bchain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign o_diff[i]     = i_a[i] ^ i_b[i] ^ w_bchain[i];
        assign w_bchain[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_bchain[i]);
    end

    assign o_borrow = w_bchain[WIDTH];

endmodule

// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed mode (sgn port, truncating fix-up) enabled by defining DIV_SIGNED_EN.
module div16_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_zero;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_dvd_in;
    logic [WIDTH-1:0] w_dvs_in;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;
    logic             w_borrow;
    logic             w_qbit;
    logic             w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

    // The shifted-out remainder MSB is the implicit 17th bit of the partial value:
    // when set, the partial exceeds any divisor regardless of the subtractor borrow.
    assign w_partial = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};

    sub16 #(
        .WIDTH (WIDTH)
    ) u_sub (
        .i_a      (w_partial),
        .i_b      (r_dvs),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    assign w_qbit     = r_rem[WIDTH-1] | ~w_borrow;
    assign w_rem_next = w_qbit ? w_trial : w_partial;
    assign w_q_next   = {r_q[WIDTH-2:0], w_qbit};

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_neg_a;
    logic w_neg_b;

    assign w_neg_a  = sgn & dividend[WIDTH-1];
    assign w_neg_b  = sgn & divisor[WIDTH-1];
    assign w_dvd_in = w_neg_a ? (~dividend + 1'b1) : dividend;
    assign w_dvs_in = w_neg_b ? (~divisor + 1'b1) : divisor;
    assign w_q_fin  = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
    assign w_r_fin  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end
`else
    assign w_dvd_in = dividend;
    assign w_dvs_in = divisor;
    assign w_q_fin  = w_q_next;
    assign w_r_fin  = w_rem_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_raw       <= '0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd      <= w_dvd_in;
                        r_dvs      <= w_dvs_in;
                        r_raw      <= dividend;
                        r_rem      <= '0;
                        r_q        <= '0;
                        r_div_zero <= 1'b0;
                        r_zero     <= (divisor == '0);
                        // A zero divisor runs only the final iteration so done lands two cycles out.
                        r_cnt      <= (divisor == '0) ? CW'(WIDTH - 1) : '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        if (r_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= r_raw;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_quotient  <= w_q_fin;
                            r_remainder <= w_r_fin;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - directed and randomized checks for div16_seq
module tb_div16_seq;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    div16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV_SIGNED_EN
        .sgn       (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa;
        int sb;
        if (b == 16'h0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic s,
                                input logic [15:0] q, input logic [15:0] r, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.q = q; v.r = r; v.z = z;
        return v;
    endfunction

    // Issues one start, follows the run to done; poke>0 re-asserts start with other operands on that cycle.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic s, input int poke,
                           output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
        int bad;
        bad = 0;
        lat = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            lat = c;
            if (c == poke) begin
                start    = 1'b1;
                dividend = 16'h0005;
                divisor  = 16'h0009;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) bad++;
            if (c == 1 && div_zero !== 1'b0) bad++;
            if (done === 1'b1) break;
        end
        check("busy_high_until_done", bad, 0);
        check("done_seen", {31'b0, done}, 1);
        q = quotient;
        r = remainder;
        z = div_zero;
        @(negedge clk);
        start = 1'b0;
        check("done_single_cycle", {31'b0, done}, 0);
        check("busy_falls_after_done", {31'b0, busy}, 0);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                             input int poke, input logic [15:0] eq, input logic [15:0] er, input logic ez);
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        run_div(a, b, s, poke, q, r, z, lat);
        check({tag, "_latency"}, lat, (b == 16'h0) ? 2 : 17);
        check({tag, "_quotient"}, {16'b0, q}, {16'b0, eq});
        check({tag, "_remainder"}, {16'b0, r}, {16'b0, er});
        check({tag, "_div_zero"}, {31'b0, z}, {31'b0, ez});
    endtask

    task automatic quiet_watch(input string tag, input int cycles, input logic [15:0] hold_q);
        int extra;
        int drift;
        extra = 0;
        drift = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done !== 1'b0) extra++;
            if (quotient !== hold_q) drift++;
        end
        check({tag, "_no_extra_done"}, extra, 0);
        check({tag, "_outputs_hold"}, drift, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;

        rst      = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = 16'h0;
        divisor  = 16'h0;

        vecs.push_back(mk(16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0));
        vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0));
        vecs.push_back(mk(16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0));
        vecs.push_back(mk(16'd1234, 16'd0,    1'b0, 16'hFFFF, 16'd1234, 1'b1));
        vecs.push_back(mk(16'd0,    16'd5,    1'b0, 16'd0,    16'd0,    1'b0));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b0, 16'd1,    16'd0,    1'b0));
        vecs.push_back(mk(16'hFFFE, 16'hFFFF, 1'b0, 16'd0,    16'hFFFE, 1'b0));
        vecs.push_back(mk(16'h8000, 16'h8001, 1'b0, 16'd0,    16'h8000, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'h8000, 1'b0, 16'd1,    16'h7FFF, 1'b0));
        vecs.push_back(mk(16'd500,  16'd3,    1'b0, 16'd166,  16'd2,    1'b0));
        vecs.push_back(mk(16'h1234, 16'h0010, 1'b0, 16'h0123, 16'h0004, 1'b0));
        vecs.push_back(mk(16'd0,    16'd0,    1'b0, 16'hFFFF, 16'd0,    1'b1));
        if (SIGNED_EN) begin
            vecs.push_back(mk(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0));
            vecs.push_back(mk(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0));
            vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0));
            vecs.push_back(mk(16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1));
            vecs.push_back(mk(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0));
        end

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_quotient", {16'b0, quotient}, 0);
        check("idle_remainder", {16'b0, remainder}, 0);
        check("idle_div_zero", {31'b0, div_zero}, 0);
        check("idle_busy", {31'b0, busy}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 0,
                      vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // Divide-by-zero flag persists through idle, then clears on the next accepted start.
        run_check("dz", 16'd1234, 16'd0, 1'b0, 0, 16'hFFFF, 16'd1234, 1'b1);
        quiet_watch("dz_idle", 5, 16'hFFFF);
        check("dz_held_in_idle", {31'b0, div_zero}, 1);
        run_check("dz_next", 16'd100, 16'd7, 1'b0, 0, 16'd14, 16'd2, 1'b0);

        // Start while busy and start in the done cycle must both be dropped.
        run_check("poke_busy", 16'hFFFF, 16'd1, 1'b0, 5, 16'hFFFF, 16'h0, 1'b0);
        quiet_watch("poke_busy", 25, 16'hFFFF);
        run_check("poke_done", 16'd100, 16'd7, 1'b0, 17, 16'd14, 16'd2, 1'b0);
        quiet_watch("poke_done", 25, 16'd14);

        // Reset in the middle of 500/3 aborts with no done.
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 16'd3;
        start    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_quotient", {16'b0, quotient}, 0);
        check("abort_remainder", {16'b0, remainder}, 0);
        check("abort_div_zero", {31'b0, div_zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet_watch("abort", 20, 16'h0);
        run_check("after_abort", 16'd500, 16'd3, 1'b0, 0, 16'd166, 16'd2, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 40));
            rs = SIGNED_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            model(ra, rb, rs, eq, er, ez);
            run_check($sformatf("rand%0d", i), ra, rb, rs, 0, eq, er, ez);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
